// File: rtl/tdm_demux_4ch.sv
// Four-slot TDM receiver: steers a serial sample stream into four channel slots and
// presents each completed frame in parallel behind a valid/ready handshake.
module tdm_demux_4ch #(
   parameter int W = 1
) (
   input  logic         CK,
   input  logic         RST,
   input  logic [W-1:0] DIN,
   input  logic         IN_VLD,
   input  logic         SOF,
   output logic [1:0]   SEL,
   output logic [W-1:0] CH0,
   output logic [W-1:0] CH1,
   output logic [W-1:0] CH2,
   output logic [W-1:0] CH3,
   output logic         OUT_VLD,
   input  logic         OUT_RDY,
   output logic         OVF,
   output logic         SYNC_ERR
);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t       state_q, state_n;
   logic [1:0]   sel_n;
   logic [W-1:0] slot_q [0:2];
   logic         wr_en;
   logic [1:0]   wr_idx;
   logic         complete;
   logic         load;
   logic         out_vld_n;
   logic         ovf_n;
   logic         sync_err_n;

   always_comb begin
      state_n    = state_q;
      sel_n      = SEL;
      wr_en      = 1'b0;
      wr_idx     = 2'd0;
      complete   = 1'b0;
      sync_err_n = 1'b0;
      case (state_q)
         IDLE: begin
            if (IN_VLD && SOF) begin
               wr_en   = 1'b1;
               wr_idx  = 2'd0;
               sel_n   = 2'd1;
               state_n = COLLECT;
            end
         end
         COLLECT: begin
            if (IN_VLD) begin
               if (SOF) begin
                  // A SOF mid-frame realigns: the partial frame is simply overwritten.
                  sync_err_n = (SEL != 2'd0);
                  wr_en      = 1'b1;
                  wr_idx     = 2'd0;
                  sel_n      = 2'd1;
               end else begin
                  wr_en    = 1'b1;
                  wr_idx   = SEL;
                  sel_n    = SEL + 2'd1;
                  complete = (SEL == 2'd3);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // A completed frame lands only if the output register is free or draining this cycle.
   assign load      = complete && (!OUT_VLD || OUT_RDY);
   assign ovf_n     = complete && !load;
   assign out_vld_n = load ? 1'b1 : ((OUT_VLD && OUT_RDY) ? 1'b0 : OUT_VLD);

   always_ff @(posedge CK) begin
      if (RST) begin
         state_q  <= IDLE;
         SEL      <= 2'd0;
         OUT_VLD  <= 1'b0;
         OVF      <= 1'b0;
         SYNC_ERR <= 1'b0;
      end else begin
         state_q  <= state_n;
         SEL      <= sel_n;
         OUT_VLD  <= out_vld_n;
         OVF      <= ovf_n;
         SYNC_ERR <= sync_err_n;
      end
   end

   // Slot 3 is never stored: it is forwarded straight from DIN on the completing edge.
   always_ff @(posedge CK) begin
      if (RST) begin
         for (int i = 0; i < 3; i++) slot_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (wr_en && (wr_idx == 2'(i))) slot_q[i] <= DIN;
         end
      end
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         CH0 <= '0;
         CH1 <= '0;
         CH2 <= '0;
         CH3 <= '0;
      end else if (load) begin
         CH0 <= slot_q[0];
         CH1 <= slot_q[1];
         CH2 <= slot_q[2];
         CH3 <= DIN;
      end
   end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch with W=4: reset, framing, gaps, resync,
// backpressure/overflow, streaming and mid-frame reset.
module tb_tdm_demux_4ch;

   localparam int W = 4;

   logic         CK = 1'b0;
   logic         RST = 1'b0;
   logic [W-1:0] DIN = '0;
   logic         IN_VLD = 1'b0;
   logic         SOF = 1'b0;
   logic [1:0]   SEL;
   logic [W-1:0] CH0, CH1, CH2, CH3;
   logic         OUT_VLD;
   logic         OUT_RDY = 1'b0;
   logic         OVF;
   logic         SYNC_ERR;

   int checks = 0;
   int errors = 0;

   tdm_demux_4ch #(.W(W)) dut (
      .CK(CK), .RST(RST), .DIN(DIN), .IN_VLD(IN_VLD), .SOF(SOF), .SEL(SEL),
      .CH0(CH0), .CH1(CH1), .CH2(CH2), .CH3(CH3), .OUT_VLD(OUT_VLD),
      .OUT_RDY(OUT_RDY), .OVF(OVF), .SYNC_ERR(SYNC_ERR)
   );

   always #5 CK = ~CK;

   // Drive one valid sample across one rising edge, then release the input.
   task automatic send(input logic [W-1:0] d, input logic s);
      DIN = d; IN_VLD = 1'b1; SOF = s;
      @(posedge CK); #1;
      IN_VLD = 1'b0; SOF = 1'b0;
   endtask

   task automatic idle(input int n);
      IN_VLD = 1'b0; SOF = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge CK); #1;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; IN_VLD = 1'b1; SOF = 1'b1; DIN = 4'hF; OUT_RDY = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge CK); #1;
         checks++;
         if ({SEL, CH0, CH1, CH2, CH3, OUT_VLD, OVF, SYNC_ERR} !== 21'd0) begin
            errors++;
            $display("FAIL reset cyc%0d: SEL=%0d CH=%h%h%h%h VLD=%b OVF=%b SERR=%b, want all 0",
                     i, SEL, CH0, CH1, CH2, CH3, OUT_VLD, OVF, SYNC_ERR);
         end
      end
      RST = 1'b0; IN_VLD = 1'b0; SOF = 1'b0;
      idle(1);
   endtask

   task automatic test_basic_frame();
      logic [1:0] exp_sel [0:3];
      logic [W-1:0] v [0:3];
      exp_sel = '{2'd1, 2'd2, 2'd3, 2'd0};
      v = '{4'hA, 4'hB, 4'hC, 4'hD};
      OUT_RDY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(v[i], i == 0);
         checks++;
         if (SEL !== exp_sel[i]) begin
            errors++;
            $display("FAIL basic_sel%0d: got %0d want %0d", i, SEL, exp_sel[i]);
         end
      end
      checks++;
      if ({OUT_VLD, CH0, CH1, CH2, CH3} !== {1'b1, 16'hABCD}) begin
         errors++;
         $display("FAIL basic_frame: VLD=%b CH=%h%h%h%h want 1 ABCD", OUT_VLD, CH0, CH1, CH2, CH3);
      end
      idle(1);
      checks++;
      if ({OUT_VLD, CH0, CH1, CH2, CH3} !== {1'b0, 16'hABCD}) begin
         errors++;
         $display("FAIL basic_accept: VLD=%b CH=%h%h%h%h want 0 ABCD", OUT_VLD, CH0, CH1, CH2, CH3);
      end
   endtask

   task automatic test_gaps();
      logic [W-1:0] v [0:3];
      v = '{4'h3, 4'h4, 4'h5, 4'h6};
      OUT_RDY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(v[i], i == 0);
         if (i == 0) begin
            checks++;
            if (SYNC_ERR !== 1'b0) begin
               errors++;
               $display("FAIL gaps_aligned_sof: SYNC_ERR=%b want 0", SYNC_ERR);
            end
         end
         if (i < 3) begin
            idle(3);
            checks++;
            if (OUT_VLD !== 1'b0) begin
               errors++;
               $display("FAIL gaps_early_vld%0d: OUT_VLD=%b want 0", i, OUT_VLD);
            end
         end
      end
      checks++;
      if ({OUT_VLD, CH0, CH1, CH2, CH3} !== {1'b1, 16'h3456}) begin
         errors++;
         $display("FAIL gaps_frame: VLD=%b CH=%h%h%h%h want 1 3456", OUT_VLD, CH0, CH1, CH2, CH3);
      end
      idle(1);
   endtask

   task automatic test_resync();
      OUT_RDY = 1'b1;
      send(4'h1, 1'b1);
      send(4'h2, 1'b0);
      send(4'h5, 1'b1);
      checks++;
      if ({SYNC_ERR, SEL} !== {1'b1, 2'd1}) begin
         errors++;
         $display("FAIL resync_err: SYNC_ERR=%b SEL=%0d want 1 1", SYNC_ERR, SEL);
      end
      send(4'h6, 1'b0);
      checks++;
      if ({SYNC_ERR, OUT_VLD} !== 2'b00) begin
         errors++;
         $display("FAIL resync_pulse: SYNC_ERR=%b OUT_VLD=%b want 0 0", SYNC_ERR, OUT_VLD);
      end
      send(4'h7, 1'b0);
      send(4'h8, 1'b0);
      checks++;
      if ({OUT_VLD, CH0, CH1, CH2, CH3} !== {1'b1, 16'h5678}) begin
         errors++;
         $display("FAIL resync_frame: VLD=%b CH=%h%h%h%h want 1 5678", OUT_VLD, CH0, CH1, CH2, CH3);
      end
      idle(1);
   endtask

   task automatic test_backpressure();
      OUT_RDY = 1'b0;
      send(4'h1, 1'b1); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
      checks++;
      if ({OUT_VLD, OVF, CH0, CH1, CH2, CH3} !== {2'b10, 16'h1234}) begin
         errors++;
         $display("FAIL bp_f1: VLD=%b OVF=%b CH=%h%h%h%h want 1 0 1234", OUT_VLD, OVF, CH0, CH1, CH2, CH3);
      end
      send(4'h9, 1'b0); send(4'hA, 1'b0); send(4'hB, 1'b0);
      checks++;
      if ({OVF, CH0, CH1, CH2, CH3} !== {1'b0, 16'h1234}) begin
         errors++;
         $display("FAIL bp_hold: OVF=%b CH=%h%h%h%h want 0 1234", OVF, CH0, CH1, CH2, CH3);
      end
      send(4'hC, 1'b0);
      checks++;
      if ({OUT_VLD, OVF, CH0, CH1, CH2, CH3} !== {2'b11, 16'h1234}) begin
         errors++;
         $display("FAIL bp_ovf: VLD=%b OVF=%b CH=%h%h%h%h want 1 1 1234", OUT_VLD, OVF, CH0, CH1, CH2, CH3);
      end
      idle(1);
      checks++;
      if ({OUT_VLD, OVF} !== 2'b10) begin
         errors++;
         $display("FAIL bp_ovf_pulse: VLD=%b OVF=%b want 1 0", OUT_VLD, OVF);
      end
      OUT_RDY = 1'b1;
      idle(1);
      checks++;
      if ({OUT_VLD, CH0, CH1, CH2, CH3} !== {1'b0, 16'h1234}) begin
         errors++;
         $display("FAIL bp_accept: VLD=%b CH=%h%h%h%h want 0 1234", OUT_VLD, CH0, CH1, CH2, CH3);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_ch;
      OUT_RDY = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 4; i++) begin
            send(4'(f * 4 + i), (f == 0) && (i == 0));
            checks++;
            if (OVF !== 1'b0) begin
               errors++;
               $display("FAIL b2b_ovf f%0d s%0d: OVF=%b want 0", f, i, OVF);
            end
         end
         exp_ch = {4'(f * 4), 4'(f * 4 + 1), 4'(f * 4 + 2), 4'(f * 4 + 3)};
         checks++;
         if ({OUT_VLD, CH0, CH1, CH2, CH3} !== {1'b1, exp_ch}) begin
            errors++;
            $display("FAIL b2b_frame%0d: VLD=%b CH=%h%h%h%h want 1 %h", f, OUT_VLD, CH0, CH1, CH2, CH3, exp_ch);
         end
      end
      send(4'h1, 1'b1);
      send(4'h2, 1'b0);
      RST = 1'b1;
      @(posedge CK); #1;
      RST = 1'b0;
      checks++;
      if ({SEL, OUT_VLD, CH0, CH1, CH2, CH3} !== 19'd0) begin
         errors++;
         $display("FAIL midrst: SEL=%0d VLD=%b CH=%h%h%h%h want 0 0 0000", SEL, OUT_VLD, CH0, CH1, CH2, CH3);
      end
      send(4'h7, 1'b0);
      checks++;
      if (SEL !== 2'd0) begin
         errors++;
         $display("FAIL idle_discard: SEL=%0d want 0", SEL);
      end
      send(4'hD, 1'b1); send(4'hE, 1'b0); send(4'hF, 1'b0);
      checks++;
      if (OUT_VLD !== 1'b0) begin
         errors++;
         $display("FAIL postrst_early: OUT_VLD=%b want 0", OUT_VLD);
      end
      send(4'h0, 1'b0);
      checks++;
      if ({OUT_VLD, SEL, CH0, CH1, CH2, CH3} !== {1'b1, 2'd0, 16'hDEF0}) begin
         errors++;
         $display("FAIL postrst_frame: VLD=%b SEL=%0d CH=%h%h%h%h want 1 0 DEF0", OUT_VLD, SEL, CH0, CH1, CH2, CH3);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_gaps();
      test_resync();
      test_backpressure();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
